// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared peripheral map, access-type encodings and 7-seg glyph lookup for the data-bus bridge
package io_bus_pkg;
  localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;
  localparam logic [11:0] OFF_SEG     = 12'h000;
  localparam logic [11:0] OFF_TIMER   = 12'h020;
  localparam logic [11:0] OFF_LED     = 12'h060;
  localparam logic [11:0] OFF_SW      = 12'h070;
  localparam logic [11:0] OFF_BTN     = 12'h078;
  typedef enum logic [1:0] {
    ACC_WORD     = 2'b00,
    ACC_HALF     = 2'b01,
    ACC_BYTE     = 2'b10,
    ACC_WORD_ALT = 2'b11
  } acc_e;
  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexes an 8-digit hex value onto active-low digit enables and segments
module seg_scanner
  import io_bus_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_i,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_code_o
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic          tc;
  assign tc = div_q == DIV_LAST;
  always_comb begin
    div_d = tc ? '0 : div_q + 1'b1;
    idx_d = tc ? idx_q + 3'd1 : idx_q;
  end
  // Outputs are registered from the current index, so they trail an index change by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      idx_q      <= '0;
      seg_en_o   <= 8'hFF;
      seg_code_o <= 8'hFF;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      seg_en_o   <= ~(8'd1 << idx_q);
      seg_code_o <= {1'b1, hex_glyph(value_i[{idx_q, 2'b00} +: 4])};
    end
  end
endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: decodes core data-bus accesses into DRAM or peripherals, with lane steering and load extension
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int DRAM_AW  = 14,
  parameter int SCAN_DIV = 50000,
  parameter int TIMER_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        bus_addr,
  input  logic [3:0]         bus_ctrl,
  input  logic [31:0]        bus_wd,
  input  logic               bus_we,
  output logic [31:0]        bus_rd,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wd,
  output logic [3:0]         dram_be,
  output logic               dram_we,
  input  logic [31:0]        dram_rd,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg_code
);
  acc_e               acc;
  logic               uns, is_half, is_byte, is_per;
  logic [9:0]         woff;
  logic               wr_seg, wr_tmr, wr_led;
  logic [31:0]        seg_q, seg_d;
  logic [23:0]        led_q, led_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [23:0]        sw_s_q, sw_q;
  logic [4:0]         btn_s_q, btn_q;
  logic [31:0]        per_rd, word_rd;
  logic [15:0]        half_rd;
  logic [7:0]         byte_rd;
  logic               unused_ctrl_we;
  assign unused_ctrl_we = bus_ctrl[0];
  assign acc     = acc_e'(bus_ctrl[2:1]);
  assign uns     = bus_ctrl[3];
  assign is_half = acc == ACC_HALF;
  assign is_byte = acc == ACC_BYTE;
  assign is_per  = bus_addr[31:12] == PERIPH_BASE;
  // Peripherals are decoded per word so narrow accesses reach any lane of a register
  assign woff    = bus_addr[11:2];
  assign wr_seg  = bus_we & is_per & (woff == OFF_SEG[11:2]);
  assign wr_tmr  = bus_we & is_per & (woff == OFF_TIMER[11:2]);
  assign wr_led  = bus_we & is_per & (woff == OFF_LED[11:2]);
  assign dram_addr = bus_addr[DRAM_AW+1:2];
  assign dram_we   = bus_we & ~is_per;
  assign dram_be   = is_byte ? 4'b0001 << bus_addr[1:0] : is_half ? (bus_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dram_wd   = is_byte ? {4{bus_wd[7:0]}} : is_half ? {2{bus_wd[15:0]}} : bus_wd;
  always_comb begin
    seg_d   = wr_seg ? bus_wd : seg_q;
    led_d   = wr_led ? bus_wd[23:0] : led_q;
    timer_d = wr_tmr ? bus_wd[TIMER_W-1:0] : timer_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      led_q   <= '0;
      timer_q <= '0;
      sw_s_q  <= '0;
      sw_q    <= '0;
      btn_s_q <= '0;
      btn_q   <= '0;
    end else begin
      seg_q   <= seg_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      sw_s_q  <= sw;
      sw_q    <= sw_s_q;
      btn_s_q <= btn;
      btn_q   <= btn_s_q;
    end
  end
  assign led = led_q;
  always_comb begin
    per_rd = woff == OFF_SEG[11:2]   ? seg_q :
             woff == OFF_TIMER[11:2] ? 32'(timer_q) :
             woff == OFF_LED[11:2]   ? {8'h00, led_q} :
             woff == OFF_SW[11:2]    ? {8'h00, sw_q} :
             woff == OFF_BTN[11:2]   ? {27'h0, btn_q} : 32'h0;
    word_rd = is_per ? per_rd : dram_rd;
    half_rd = bus_addr[1] ? word_rd[31:16] : word_rd[15:0];
    byte_rd = word_rd[{bus_addr[1:0], 3'b000} +: 8];
    bus_rd  = is_byte ? {{24{~uns & byte_rd[7]}}, byte_rd} :
              is_half ? {{16{~uns & half_rd[15]}}, half_rd} : word_rd;
  end
  seg_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (seg_q),
    .seg_en_o  (seg_en),
    .seg_code_o(seg_code)
  );
endmodule

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge: scoreboard bench with a byte-level memory/peripheral reference model
module tb_io_bus_bridge;
  localparam int AW = 14;
  localparam int SD = 4;
  logic          clk = 0, rst_n = 0;
  logic [31:0]   bus_addr = 0, bus_wd = 0, bus_rd, dram_wd, dram_rd;
  logic [3:0]    bus_ctrl = 0, dram_be;
  logic          bus_we = 0, dram_we;
  logic [AW-1:0] dram_addr;
  logic [23:0]   sw = 0, led;
  logic [4:0]    btn = 0;
  logic [7:0]    seg_en, seg_code;

  io_bus_bridge #(.DRAM_AW(AW), .SCAN_DIV(SD), .TIMER_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wd(bus_wd),
    .bus_we(bus_we), .bus_rd(bus_rd), .dram_addr(dram_addr), .dram_wd(dram_wd),
    .dram_be(dram_be), .dram_we(dram_we), .dram_rd(dram_rd), .sw(sw), .btn(btn),
    .led(led), .seg_en(seg_en), .seg_code(seg_code)
  );

  always #5 clk = ~clk;

  // Environment DRAM: asynchronous read, byte-enabled synchronous write
  logic [31:0] dram [0:(1<<AW)-1] = '{default: 32'h0};
  assign dram_rd = dram[dram_addr];
  always @(posedge clk)
    if (dram_we)
      for (int i = 0; i < 4; i++)
        if (dram_be[i]) dram[dram_addr][8*i +: 8] <= dram_wd[8*i +: 8];

  typedef struct {
    int          kind;
    logic [31:0] exp;
    logic [31:0] alt;
    bit          has_alt;
    string       tag;
  } chk_t;
  chk_t sb[$];
  int n_probe = 0, n_cmp = 0, n_bad = 0;
  int edge_n = 0, rel_edge = 0, tm_edge = 0;
  logic [31:0] tm_base = 0, seg_m = 0, led_m = 0, sw_m = 0, btn_m = 0;
  logic [7:0]  ref_mem [int];
  logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [31:0] actual(input int k);
    case (k)
      0: return bus_rd;
      1: return {28'h0, dram_be};
      2: return dram_wd;
      3: return {31'h0, dram_we};
      4: return {8'h0, led};
      5: return {24'h0, seg_en};
      default: return {24'h0, seg_code};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < n_probe; i++) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: nothing expected");
      end else begin
        chk_t c;
        logic [31:0] a;
        c = sb.pop_front();
        a = actual(c.kind);
        if (!(a === c.exp || (c.has_alt && a === c.alt))) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", c.tag, a, c.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    n_probe = 0;
  endtask

  task automatic push2(input int k, input logic [31:0] e, input logic [31:0] alt, input bit ha, input string tag);
    chk_t c;
    c.kind = k; c.exp = e; c.alt = alt; c.has_alt = ha; c.tag = tag;
    sb.push_back(c);
    n_probe++;
  endtask

  task automatic push(input int k, input logic [31:0] e, input string tag);
    push2(k, e, e, 1'b0, tag);
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] c, input logic [31:0] d, input logic we);
    tick();
    bus_addr = a; bus_ctrl = c; bus_wd = d; bus_we = we;
  endtask

  function automatic bit is_per(input logic [31:0] a);
    return a[31:12] == 20'hFFFFF;
  endfunction

  function automatic int size_of(input logic [1:0] t);
    return t == 2'b01 ? 2 : t == 2'b10 ? 1 : 4;
  endfunction

  function automatic int lane_of(input logic [31:0] a, input logic [1:0] t);
    int s;
    s = size_of(t);
    return s == 4 ? 0 : s == 2 ? (a[1] ? 2 : 0) : int'(a[1:0]);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r, base;
    base = a & 32'h0000_FFFC;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = ref_mem.exists(int'(base) + i) ? ref_mem[int'(base) + i] : 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] per_word(input logic [31:0] a);
    case (a & 32'hFFC)
      32'h000: return seg_m;
      32'h020: return tm_base + 32'(edge_n - tm_edge);
      32'h060: return led_m;
      32'h070: return sw_m;
      32'h078: return btn_m;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] t, input logic u);
    logic [31:0] w, v, m;
    int s;
    w = is_per(a) ? per_word(a) : mem_word(a);
    s = size_of(t);
    v = w >> (8 * lane_of(a, t));
    if (s == 4) return v;
    m = s == 1 ? 32'hFF : 32'hFFFF;
    v = v & m;
    if (!u && v[8*s-1]) v = v | ~m;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    int s, o;
    if (is_per(a)) begin
      case (a & 32'hFFC)
        32'h000: seg_m = d;
        32'h020: begin tm_base = d; tm_edge = edge_n + 1; end
        32'h060: led_m = d & 32'h00FF_FFFF;
        default: ;
      endcase
    end else begin
      s = size_of(t);
      o = lane_of(a, t);
      for (int i = 0; i < s; i++) ref_mem[int'(a & 32'h0000_FFFC) + o + i] = d[8*i +: 8];
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d, input string tag);
    logic [3:0]  be;
    logic [31:0] wd;
    int s, o;
    drive(a, {1'b0, t, 1'b1}, d, 1'b1);
    if (is_per(a)) push(3, 0, {tag, "_we"});
    else begin
      s = size_of(t);
      o = lane_of(a, t);
      be = 0;
      for (int i = 0; i < s; i++) be[o+i] = 1'b1;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % s) +: 8];
      push(3, 1, {tag, "_we"});
      push(1, {28'h0, be}, {tag, "_be"});
      push(2, wd, {tag, "_wd"});
    end
    model_store(a, t, d);
  endtask

  task automatic ldk(input logic [31:0] a, input logic [1:0] t, input logic u, input logic [31:0] e, input string tag);
    drive(a, {u, t, 1'b0}, 32'h0, 1'b0);
    push(0, e, tag);
  endtask

  task automatic ldm(input logic [31:0] a, input logic [1:0] t, input logic u, input string tag);
    drive(a, {u, t, 1'b0}, 32'h0, 1'b0);
    push(0, exp_load(a, t, u), tag);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0; bus_we = 0; bus_addr = 32'hFFFFF060; bus_ctrl = 0;
    push(5, 32'hFF, "rst_seg_en");
    push(6, 32'hFF, "rst_seg_code");
    push(4, 0, "rst_led");
    push(0, 0, "rst_led_rd");
    tick();
    tick();
    rst_n = 1;
    rel_edge = edge_n; tm_edge = edge_n; tm_base = 0; seg_m = 0; led_m = 0;
  endtask

  task automatic scan_check(input string tag);
    int m, idx;
    m = edge_n - rel_edge;
    idx = m == 0 ? 0 : ((m - 1) / SD) % 8;
    push(5, m == 0 ? 32'hFF : {24'h0, ~(8'd1 << idx)}, {tag, "_en"});
    push(6, m == 0 ? 32'hFF : {24'h0, glyph[(seg_m >> (4 * idx)) & 32'hF]}, {tag, "_code"});
  endtask

  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;
  logic [31:0] p_wr [5] = '{32'h000, 32'h020, 32'h060, 32'h010, 32'h040};
  logic [31:0] p_rd [6] = '{32'h000, 32'h020, 32'h060, 32'h070, 32'h078, 32'h010};

  initial begin
    do_reset();
    st(32'h100, W, 32'h80123456, "st_word");
    drive(32'h101, {1'b0, B, 1'b1}, 32'h000000AB, 1'b1);
    push(1, 32'h2, "byte_be");
    push(2, 32'hABABABAB, "byte_wd");
    push(3, 1, "byte_we");
    model_store(32'h101, B, 32'hAB);
    ldk(32'h100, W, 0, 32'h8012AB56, "word_after_byte");
    st(32'h100, W, 32'h80123456, "st_word2");
    ldk(32'h103, B, 0, 32'hFFFFFF80, "lb_signed");
    ldk(32'h103, B, 1, 32'h00000080, "lb_unsigned");
    ldk(32'h102, H, 0, 32'hFFFF8012, "lh_signed");
    ldk(32'h100, H, 1, 32'h00003456, "lh_unsigned");
    st(32'hFFFFF060, W, 32'hFFABCDEF, "st_led");
    ldk(32'hFFFFF060, W, 0, 32'h00ABCDEF, "led_rd");
    push(4, 32'h00ABCDEF, "led_out");
    ldk(32'hFFFFF060, B, 0, 32'hFFFFFFEF, "led_sbyte");
    st(32'hFFFFF010, W, 32'h12345678, "st_unmapped");
    ldk(32'hFFFFF010, W, 0, 32'h0, "unmapped_rd");
    push(4, 32'h00ABCDEF, "led_kept");
    st(32'hFFFFF020, W, 32'hFFFFFFFE, "st_timer");
    ldk(32'hFFFFF020, W, 0, 32'hFFFFFFFE, "timer_0");
    ldk(32'hFFFFF020, W, 0, 32'hFFFFFFFF, "timer_1");
    ldk(32'hFFFFF020, W, 0, 32'h00000000, "timer_2");
    drive(32'hFFFFF070, {1'b0, W, 1'b0}, 0, 0);
    sw = 24'h00F00F; btn = 5'h15;
    push(0, 0, "sw_c0");
    ldk(32'hFFFFF070, W, 0, 32'h0, "sw_c1");
    drive(32'hFFFFF070, {1'b0, W, 1'b0}, 0, 0);
    push2(0, 32'h00F00F, 32'h0, 1'b1, "sw_c2");
    ldk(32'hFFFFF070, W, 0, 32'h00F00F, "sw_c3");
    sw_m = 32'h00F00F; btn_m = 32'h15;
    ldk(32'hFFFFF078, B, 1, 32'h15, "btn_rd");
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d;
      logic [1:0] t;
      logic u;
      a = $urandom & 32'h0003_00FF;
      d = $urandom;
      t = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: st(a, t, d, "rnd_st");
        1: ldm(a, t, u, "rnd_ld");
        2: st(32'hFFFFF000 | p_wr[$urandom_range(0, 4)], t, d, "rnd_pst");
        default: ldm(32'hFFFFF000 | p_rd[$urandom_range(0, 5)], t, u, "rnd_pld");
      endcase
    end
    do_reset();
    st(32'hFFFFF000, W, 32'h76543210, "st_seg");
    for (int n = 0; n < 40; n++) begin
      drive(32'h0, 4'h0, 32'h0, 1'b0);
      scan_check("scan");
    end
    do_reset();
    for (int n = 0; n < 6; n++) begin
      drive(32'h0, 4'h0, 32'h0, 1'b0);
      scan_check("post_rst");
    end
    ldm(32'h101, B, 1, "dram_kept");
    tick();
    tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/io_bus_bridge.md
# io_bus_bridge

Memory-side responder for the CPU core's data bus. Decodes each MEM-stage access into either the data DRAM or a small set of memory-mapped peripherals. For stores it drives byte-lane write enables. For loads it returns lane-extracted, sign- or zero-extended data in the same cycle. It owns the peripheral state: LEDs, a 7-segment display with a scan FSM, synchronised switches and buttons, and a free-running timer.

## Interface
Parameters:
- DRAM_AW, 14: DRAM word-address width (64 KiB).
- SCAN_DIV, 50000: clk cycles per 7-seg digit slot; must be ≥ 2.
- TIMER_W, 32: timer width; must be ≤ 32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bus_addr  in  32  byte address from the core.
- bus_ctrl  in  4  {unsigned, type[1:0], we}. Type encoding: 00 word, 01 half, 10 byte, 11 treated as word.
- bus_wd  in  32  store data, right-aligned.
- bus_we  in  1  store strobe; the only write qualifier (bus_ctrl[0] is ignored).
- bus_rd  out  32  load data, combinational.
- dram_addr  out  DRAM_AW  word address, bus_addr[DRAM_AW+1:2].
- dram_wd  out  32  lane-replicated store data.
- dram_be  out  4  byte enables.
- dram_we  out  1  DRAM write strobe.
- dram_rd  in  32  DRAM word; asynchronous read.
- sw  in  24  switches; asynchronous.
- btn  in  5  buttons; asynchronous.
- led  out  24  LED register.
- seg_en  out  8  digit enables, active-low.
- seg_code  out  8  {dp, g..a} segments, active-low; dp is always 1.

## Operation
- **Address decode**
  - Peripheral when bus_addr[31:12] = 0xFFFFF; otherwise DRAM.
  - Peripheral offsets (bus_addr[11:0]): 0x000 SEG (R/W), 0x020 TIMER (R/W), 0x060 LED (R/W), 0x070 SW (R), 0x078 BTN (R).
  - Unmapped peripheral offsets: reads return 0, writes are dropped.
- **Lane selection**
  - Word: ignores addr[1:0].
  - Half: lane chosen by addr[1]; addr[0] is ignored.
  - Byte: lane chosen by addr[1:0].
- **Stores to DRAM**
  - dram_we = bus_we & DRAM-hit.
  - dram_be: word 1111; half 0011 or 1100; byte one-hot 0001 << addr[1:0].
  - dram_wd: word = bus_wd; half = {2{bus_wd[15:0]}}; byte = {4{bus_wd[7:0]}}.
- **Loads**
  - The selected lane is shifted to the LSBs.
  - unsigned=0: sign-extend. unsigned=1: zero-extend.
  - Extension applies to peripheral reads as well as DRAM reads.
- **Peripheral writes**
  - Always full-word; type is ignored.
  - Registers update at the next posedge clk after bus_we=1.
  - LED keeps bits [23:0] of the write data; SEG and TIMER take all bits.
- **Switches and buttons**: each passes through a 2-flop synchroniser; reads return zero-extended values.
- **Timer**
  - Increments every cycle and wraps at 2^TIMER_W.
  - A write loads the written value; a write and an increment in the same cycle resolve to the write.
- **Scan FSM**
  - Divider counts 0..SCAN_DIV-1; on terminal count the digit index advances 0→1→…→7→0.
  - seg_en = ~(1 << idx).
  - seg_code = hex glyph of SEG[4·idx+3 : 4·idx].

## Timing
- bus_rd is combinational from bus_addr, bus_ctrl, dram_rd and the registered peripheral state, so loads complete in 0 cycles. DRAM outputs are likewise combinational.
- A peripheral write becomes visible to reads starting the cycle after the write.
- Timer: a write of V at edge k reads V in cycle k and V+1 in cycle k+1.
- A sw/btn change appears in reads 2–3 cycles later.
- seg_code and seg_en are registered and update one cycle after an idx change or a SEG write.
- Reset values:
  - led = 0, SEG = 0, timer = 0, synchronisers = 0.
  - Divider = 0, idx = 0.
  - seg_en = 8'hFF, seg_code = 8'hFF; the first scan slot begins on the first cycle after reset.
- Reset asserted mid-scan or mid-count returns all state to reset values immediately. DRAM contents are not affected.

## Structure
- Package io_bus_pkg holds:
  - Peripheral base and offset constants.
  - Access-type encodings (WORD/HALF/BYTE).
  - hex→7-seg glyph function.
- Sub-module seg_scanner contains the divider, digit index, and registered seg_en/seg_code. Inputs: clk, rst_n, 32-bit value. Parameter: SCAN_DIV.
- The top level contains the decode, lane logic, and peripheral registers.

## Test plan
- **DRAM word/byte stores**: store word 0x80123456 @0x100, then store byte 0xAB @0x101. Expect dram_be=0010 and dram_wd=0xABABABAB; a subsequent word load returns 0x8012AB56.
- **Sign/zero extension**: DRAM word 0x80123456 @0x100. Signed byte load @0x103 → 0xFFFFFF80. Unsigned byte @0x103 → 0x00000080. Signed half @0x102 → 0xFFFF8012. Unsigned half @0x100 → 0x00003456.
- **LED and unmapped offsets**: store 0xFFABCDEF to 0xFFFFF060 → led = 0xABCDEF next cycle, and readback is 0x00ABCDEF. Store to 0xFFFFF010 → no state change, read 0.
- **Timer**: write 0xFFFFFFFE to 0xFFFFF020 → reads in following cycles give 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- **Scan and reset**: with SCAN_DIV=4 and SEG=0x76543210, expect seg_en to cycle FE, FD, …, 7F every 4 cycles with digit 0 showing glyph '0' (0xC0). Asserting rst_n=0 mid-scan → seg_en=0xFF immediately.
- **Switch sync**: sw changes to 0x00F00F → a load from 0xFFFFF070 returns 0x00F00F by the 3rd cycle, and never earlier than the 2nd.
